log_page_buffer: RTL
====================

Name: log_page_buffer

Overview:
- Upstream feeder for the 24LC256 I2C leader in the data logger.
- Collects 8-bit sample bytes into two ping-pong page buffers and tracks the 15-bit EEPROM write address.
- Issues page-aligned write commands (at most 64 bytes, never crossing a 64-byte EEPROM page) to the I2C leader through a request/ack/stream/done handshake, with retry on write error.

Parameters:
- PAGE_BYTES, 64, EEPROM page size; power of two.
- ADDR_W, 15, EEPROM byte address width (32 KiB).
- START_ADDR, 0, first EEPROM address written after reset.
- MAX_RETRY, 3, re-issues of one page after wr_err before the page is dropped.

Ports:
- CLK_50MHz  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- sample_valid  in  1  upstream byte valid
- sample_data  in  8  upstream byte
- sample_ready  out  1  byte accepted when valid&ready
- flush  in  1  single-cycle pulse; close the partially filled page
- wr_req  out  1  page command pending to I2C leader
- wr_addr  out  ADDR_W  EEPROM start address of page command
- wr_len  out  7  byte count, 1..PAGE_BYTES
- wr_ack  in  1  leader accepted command
- byte_data  out  8  current byte of page being sent
- byte_rd  in  1  leader consumed byte_data
- wr_done  in  1  page write complete, including ack polling
- wr_err  in  1  page write failed (NACK)
- mem_full  out  1  last EEPROM address filled; logging stopped
- err_sticky  out  1  a page was dropped after MAX_RETRY failures

Behaviour:
- Reset, asynchronous, any state:
  - outputs: wr_req=0, sample_ready=0 during reset and 1 from the first clock after release; mem_full=0, err_sticky=0, wr_len=0, wr_addr=START_ADDR, byte_data=0.
  - internal: both buffers empty, fill address = START_ADDR, retry count 0, FSM=IDLE.
  - Any in-flight page is discarded; the leader is expected to be reset together with this block.
- Fill side:
  - Accept when sample_valid&sample_ready. The byte is stored in the fill buffer and the fill address increments.
  - The fill buffer closes (becomes ready) when either:
    - the accepted byte sits at address offset PAGE_BYTES-1 (page boundary), or
    - flush is seen while the buffer holds at least 1 byte.
  - flush on an empty buffer is ignored.
  - flush in the same cycle as an accepted byte: that byte is included, then the buffer closes.
  - After a partial flush, the next buffer starts mid-page and closes at the next page boundary, so no command ever crosses a page.
  - On close, fill switches to the other buffer. If the other buffer is not free, sample_ready=0 until it is freed.
  - Accepting the byte at address 2^ADDR_W-1 closes the buffer and sets mem_full=1. sample_ready then stays 0 until reset. There is no wrap-around.
- Issue FSM:
  - IDLE: a closed buffer exists -> REQ. wr_addr and wr_len are loaded from that buffer and wr_req=1.
  - REQ: wr_req held high; wr_addr and wr_len stable. wr_ack -> STREAM, wr_req=0 in the next cycle.
  - STREAM:
    - byte_data shows the byte at the read pointer (registered, valid from STREAM entry).
    - byte_rd advances the pointer; the next byte appears the following cycle.
    - byte_rd after wr_len bytes is ignored.
    - wr_done or wr_err -> WAIT_DONE handling, same cycle.
  - On wr_done: the buffer is freed, retry count cleared, FSM -> IDLE.
  - On wr_err:
    - retry count < MAX_RETRY: increment, rewind the read pointer, go to REQ with the same address and length.
    - otherwise: free the buffer, set err_sticky, clear retry count, go to IDLE.
  - wr_done and wr_err in the same cycle: wr_done wins.
  - Buffers are issued in close order. Fill and issue run concurrently on different buffers.
- Latency:
  - Page-boundary close to wr_req=1: 2 cycles.
  - flush to wr_req=1: 2 cycles.

Test Plan:
- Reset, then 64 bytes 0x00..0x3F -> wr_req 2 cycles after the 64th byte, wr_addr=0x0000, wr_len=64. With byte_rd pulses, byte_data sequence is 0x00..0x3F. wr_done frees the buffer.
- 10 bytes then a flush pulse, then 60 bytes -> first command addr 0x0000 len 10. Second command addr 0x000A len 54 (boundary). Remaining 6 bytes are held at addr 0x0040.
- Leader stalls (no wr_ack) while 128 bytes are offered -> both buffers fill and sample_ready=0 after byte 128. After wr_ack and wr_done, sample_ready returns to 1.
- wr_err on page at 0x0040 three times, then wr_done -> four requests, all addr 0x0040 and len 64 with identical data; err_sticky=0. With four wr_err -> page dropped, err_sticky=1, next page is issued.
- START_ADDR=0x7FC0, fill 64 bytes -> command addr 0x7FC0 len 64, mem_full=1, sample_ready=0 permanently. Further sample_valid is not accepted.
- RESET asserted mid-STREAM -> wr_req and mem_full go to 0 immediately (asynchronous). After release, the first command uses wr_addr=START_ADDR.

Source files
------------

// File: rtl/log_page_buffer.sv
// Ping-pong page collector feeding the 24LC256 I2C leader: packs sample bytes into
// page-aligned write commands and re-issues a page after wr_err up to MAX_RETRY times.
module log_page_buffer #(
  parameter int PAGE_BYTES = 64,
  parameter int ADDR_W     = 15,
  parameter int START_ADDR = 0,
  parameter int MAX_RETRY  = 3
) (
  input  logic              CLK_50MHz,
  input  logic              RESET,
  input  logic              sample_valid,
  input  logic [7:0]        sample_data,
  output logic              sample_ready,
  input  logic              flush,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [6:0]        wr_len,
  input  logic              wr_ack,
  output logic [7:0]        byte_data,
  input  logic              byte_rd,
  input  logic              wr_done,
  input  logic              wr_err,
  output logic              mem_full,
  output logic              err_sticky,
  output logic [1:0]        dbg_state_o
);

  localparam int OFF_W = $clog2(PAGE_BYTES);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_STREAM} state_t;

  // Handshakes: a sample byte moves when sample_valid & sample_ready at a rising edge.
  // wr_req stays high with wr_addr/wr_len stable until wr_ack; afterwards each byte_rd
  // consumes byte_data and the next byte is presented on the following cycle.

  state_t               state_q;
  logic                 fill_sel_q, issue_sel_q;
  logic [1:0]           full_q;
  logic [6:0]           cnt_q [2];
  logic [ADDR_W-1:0]    base_q [2];
  logic [ADDR_W-1:0]    fill_addr_q;
  logic                 ready_en_q, mem_full_q, err_sticky_q;
  logic                 wr_req_q;
  logic [ADDR_W-1:0]    wr_addr_q;
  logic [6:0]           wr_len_q;
  logic [7:0]           byte_data_q;
  logic [OFF_W-1:0]     rd_off_q;
  logic [6:0]           rd_cnt_q;
  logic [RTY_W-1:0]     retry_q;
  logic [7:0]           mem_q [2*PAGE_BYTES];

  logic                 accept, at_boundary, at_top, close_fill;
  logic [OFF_W-1:0]     rd_off_d;

  assign sample_ready = ready_en_q & ~full_q[fill_sel_q] & ~mem_full_q;
  assign accept       = sample_valid & sample_ready;
  assign at_boundary  = (fill_addr_q[OFF_W-1:0] == '1);
  assign at_top       = (fill_addr_q == '1);
  // A flush only closes a buffer that is actually being filled and holds data.
  assign close_fill   = (accept & (at_boundary | at_top | flush)) |
                        (flush & ~full_q[fill_sel_q] & (cnt_q[fill_sel_q] != 7'd0));
  assign rd_off_d     = rd_off_q + OFF_W'(1);

  assign wr_req      = wr_req_q;
  assign wr_addr     = wr_addr_q;
  assign wr_len      = wr_len_q;
  assign byte_data   = byte_data_q;
  assign mem_full    = mem_full_q;
  assign err_sticky  = err_sticky_q;
  assign dbg_state_o = state_q;

  // Bytes are stored at their page offset so a mid-page start needs no realignment.
  always_ff @(posedge CLK_50MHz) begin
    if (accept) mem_q[{fill_sel_q, fill_addr_q[OFF_W-1:0]}] <= sample_data;
  end

  always_ff @(posedge CLK_50MHz or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      fill_sel_q   <= 1'b0;
      issue_sel_q  <= 1'b0;
      full_q       <= 2'b00;
      cnt_q[0]     <= 7'd0;
      cnt_q[1]     <= 7'd0;
      base_q[0]    <= ADDR_W'(START_ADDR);
      base_q[1]    <= ADDR_W'(START_ADDR);
      fill_addr_q  <= ADDR_W'(START_ADDR);
      ready_en_q   <= 1'b0;
      mem_full_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      wr_req_q     <= 1'b0;
      wr_addr_q    <= ADDR_W'(START_ADDR);
      wr_len_q     <= 7'd0;
      byte_data_q  <= 8'd0;
      rd_off_q     <= '0;
      rd_cnt_q     <= 7'd0;
      retry_q      <= '0;
    end else begin
      ready_en_q <= 1'b1;

      if (accept) begin
        if (cnt_q[fill_sel_q] == 7'd0) base_q[fill_sel_q] <= fill_addr_q;
        cnt_q[fill_sel_q] <= cnt_q[fill_sel_q] + 7'd1;
        fill_addr_q       <= fill_addr_q + ADDR_W'(1);
        if (at_top) mem_full_q <= 1'b1;
      end
      if (close_fill) begin
        full_q[fill_sel_q] <= 1'b1;
        fill_sel_q         <= ~fill_sel_q;
      end

      // The issue side only ever frees the full buffer at issue_sel_q, while the fill
      // side only touches a non-full buffer, so the two never update the same entry.
      case (state_q)
        S_IDLE: begin
          if (full_q[issue_sel_q]) begin
            wr_addr_q <= base_q[issue_sel_q];
            wr_len_q  <= cnt_q[issue_sel_q];
            wr_req_q  <= 1'b1;
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          if (wr_ack) begin
            wr_req_q    <= 1'b0;
            rd_off_q    <= wr_addr_q[OFF_W-1:0];
            rd_cnt_q    <= 7'd0;
            byte_data_q <= mem_q[{issue_sel_q, wr_addr_q[OFF_W-1:0]}];
            state_q     <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (wr_done || (wr_err && retry_q >= RTY_W'(MAX_RETRY))) begin
            full_q[issue_sel_q] <= 1'b0;
            cnt_q[issue_sel_q]  <= 7'd0;
            issue_sel_q         <= ~issue_sel_q;
            retry_q             <= '0;
            if (!wr_done) err_sticky_q <= 1'b1;
            state_q             <= S_IDLE;
          end else if (wr_err) begin
            retry_q  <= retry_q + RTY_W'(1);
            wr_req_q <= 1'b1;
            state_q  <= S_REQ;
          end else if (byte_rd && rd_cnt_q < wr_len_q) begin
            rd_cnt_q <= rd_cnt_q + 7'd1;
            if (rd_cnt_q + 7'd1 < wr_len_q) begin
              rd_off_q    <= rd_off_d;
              byte_data_q <= mem_q[{issue_sel_q, rd_off_d}];
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
